// File: rtl/banco_arbitro_pkg.sv
// Shared types and constants for the two-port register-bank access controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
`timescale 1ns/1ps
package banco_arbitro_pkg;

    localparam int W_DFLT    = 4;
    localparam int NREG_DFLT = 4;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ACC  = 2'd1;
    localparam logic [1:0] ST_ACK  = 2'd2;

    localparam logic PORT_A = 1'b0;
    localparam logic PORT_B = 1'b1;

    typedef enum logic [1:0] {
        S_IDLE = ST_IDLE,
        S_ACC  = ST_ACC,
        S_ACK  = ST_ACK
    } state_t;

    // One-hot register enable from a 2-bit address, gated by the write strobe.
    function automatic logic [NREG_DFLT-1:0] addr_dec(input logic [1:0] a, input logic en);
        logic [NREG_DFLT-1:0] v;
        v = '0;
        if (en) begin
            v[a] = 1'b1;
        end
        return v;
    endfunction

endpackage

// File: rtl/banco_arbitro_bank.sv
// Four W-bit registers written through a decoded address, all contents exported.
// Latency: write visible on o_q_all one cycle after i_we is sampled.
// Backpressure: none; every enabled cycle writes.
`timescale 1ns/1ps
module banco_4reg_4b
    import banco_arbitro_pkg::*;
#(
    parameter int W = W_DFLT
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    input  logic                   i_we,
    input  logic [1:0]             i_waddr,
    input  logic [W-1:0]           i_wdata,
    output logic [NREG_DFLT*W-1:0] o_q_all
);

    logic [W-1:0]         r_q [NREG_DFLT];
    logic [NREG_DFLT-1:0] w_en;

    assign w_en = addr_dec(i_waddr, i_we);

    // Register array: reset wins over any pending write.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int i = 0; i < NREG_DFLT; i++) begin
                r_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NREG_DFLT; i++) begin
                if (w_en[i]) begin
                    r_q[i] <= i_wdata;
                end
            end
        end
    end

    for (genvar g = 0; g < NREG_DFLT; g++) begin : g_out
        assign o_q_all[g*W +: W] = r_q[g];
    end

endmodule

// File: rtl/banco_arbitro.sv
// Arbitrates ports A/B onto the register bank; each access runs IDLE -> ACC -> ACK.
// Latency: grant one cycle after the request is sampled, ack one cycle later; 3 cycles per access.
// Backpressure: the losing port keeps its level request until granted; BANCO_RR_EN selects round-robin ties.
`timescale 1ns/1ps
module banco_arbitro
    import banco_arbitro_pkg::*;
#(
    parameter int W    = W_DFLT,
    parameter int NREG = NREG_DFLT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_a,
    input  logic              req_b,
    input  logic              we_a,
    input  logic              we_b,
    input  logic [1:0]        addr_a,
    input  logic [1:0]        addr_b,
    input  logic [W-1:0]      wdata_a,
    input  logic [W-1:0]      wdata_b,
    output logic              gnt_a,
    output logic              gnt_b,
    output logic              ack_a,
    output logic              ack_b,
    output logic [W-1:0]      rdata_a,
    output logic [W-1:0]      rdata_b,
    output logic              busy,
    output logic [NREG*W-1:0] q_all
);

    state_t          r_state;
    state_t          w_state_nxt;
    logic            w_req_any;
    logic            w_win_b;
    logic            w_port_nxt;
    logic            w_own;
    logic            w_bank_we;
    logic [W-1:0]    w_rd;
    logic [NREG*W-1:0] w_q_all;

    logic            r_port;
    logic            r_we;
    logic [1:0]      r_addr;
    logic [W-1:0]    r_wdata;

    logic            r_gnt_a;
    logic            r_gnt_b;
    logic            r_ack_a;
    logic            r_ack_b;
    logic            r_busy;
    logic [W-1:0]    r_rdata_a;
    logic [W-1:0]    r_rdata_b;

    assign w_req_any = req_a | req_b;

`ifdef BANCO_RR_EN
    // Set when B won the most recent arbitration; starts as "B served last" so A wins the first tie.
    logic r_last_b;

    assign w_win_b = req_b & (~req_a | ~r_last_b);

    // Pointer moves when a winner is committed, i.e. on entry to ACC.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_last_b <= 1'b1;
        end else if (r_state == S_IDLE && w_req_any) begin
            r_last_b <= w_win_b;
        end
    end
`else
    // Fixed priority: B only wins when A is not asking.
    assign w_win_b = req_b & ~req_a;
`endif

    // Port owning the bank in the next state: fresh winner from IDLE, latched port otherwise.
    assign w_port_nxt = (r_state == S_IDLE) ? w_win_b : r_port;
    assign w_own      = (w_state_nxt != S_IDLE);
    assign w_rd       = w_q_all[int'(r_addr)*W +: W];

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode; the bank write strobe is high only for the ACC cycle of a write.
    always_comb begin
        w_state_nxt = r_state;
        w_bank_we   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_req_any) begin
                    w_state_nxt = S_ACC;
                end
            end
            S_ACC: begin
                w_bank_we   = r_we;
                w_state_nxt = S_ACK;
            end
            S_ACK: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Command latch: captured once in IDLE, later changes on the winner's inputs are ignored.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_port  <= PORT_A;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else if (r_state == S_IDLE && w_req_any) begin
            r_port  <= w_win_b;
            r_we    <= w_win_b ? we_b    : we_a;
            r_addr  <= w_win_b ? addr_b  : addr_a;
            r_wdata <= w_win_b ? wdata_b : wdata_a;
        end
    end

    // Registered outputs decoded from the next state so they line up with ACC/ACK.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_gnt_a   <= 1'b0;
            r_gnt_b   <= 1'b0;
            r_ack_a   <= 1'b0;
            r_ack_b   <= 1'b0;
            r_busy    <= 1'b0;
            r_rdata_a <= '0;
            r_rdata_b <= '0;
        end else begin
            r_gnt_a <= w_own & (w_port_nxt == PORT_A);
            r_gnt_b <= w_own & (w_port_nxt == PORT_B);
            r_busy  <= w_own;
            r_ack_a <= (w_state_nxt == S_ACK) & (r_port == PORT_A);
            r_ack_b <= (w_state_nxt == S_ACK) & (r_port == PORT_B);
            if (w_state_nxt == S_ACK && !r_we) begin
                if (r_port == PORT_A) begin
                    r_rdata_a <= w_rd;
                end else begin
                    r_rdata_b <= w_rd;
                end
            end
        end
    end

    banco_4reg_4b #(
        .W (W)
    ) u_bank (
        .i_clk   (clk),
        .i_reset (reset),
        .i_we    (w_bank_we),
        .i_waddr (r_addr),
        .i_wdata (r_wdata),
        .o_q_all (w_q_all)
    );

    assign gnt_a   = r_gnt_a;
    assign gnt_b   = r_gnt_b;
    assign ack_a   = r_ack_a;
    assign ack_b   = r_ack_b;
    assign busy    = r_busy;
    assign rdata_a = r_rdata_a;
    assign rdata_b = r_rdata_b;
    assign q_all   = w_q_all;

endmodule

// File: tb/tb_banco_arbitro.sv
// Self-checking bench for banco_arbitro: vector table, corner sequences, random vs. reference model.
// Latency: n/a.
// Backpressure: n/a.
`timescale 1ns/1ps
module tb_banco_arbitro;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_a, req_b, we_a, we_b;
    logic [1:0]  addr_a, addr_b;
    logic [3:0]  wdata_a, wdata_b;
    logic        gnt_a, gnt_b, ack_a, ack_b, busy;
    logic [3:0]  rdata_a, rdata_b;
    logic [15:0] q_all;

    int n_chk  = 0;
    int n_fail = 0;

    banco_arbitro dut (
        .clk     (clk),
        .reset   (reset),
        .req_a   (req_a),
        .req_b   (req_b),
        .we_a    (we_a),
        .we_b    (we_b),
        .addr_a  (addr_a),
        .addr_b  (addr_b),
        .wdata_a (wdata_a),
        .wdata_b (wdata_b),
        .gnt_a   (gnt_a),
        .gnt_b   (gnt_b),
        .ack_a   (ack_a),
        .ack_b   (ack_b),
        .rdata_a (rdata_a),
        .rdata_b (rdata_b),
        .busy    (busy),
        .q_all   (q_all)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        ra, rb, wa, wb;
        logic [1:0]  aa, ab;
        logic [3:0]  da, db;
        logic        win_b;
        logic [15:0] q;
        logic [3:0]  rd;
    } vec_t;

    vec_t tbl[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        req_a = 1'b0; req_b = 1'b0; we_a = 1'b0; we_b = 1'b0;
        addr_a = 2'd0; addr_b = 2'd0; wdata_a = 4'h0; wdata_b = 4'h0;
    endtask

    task automatic do_reset();
        quiet();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        tick();
    endtask

    // Reference model state for the random phase.
    logic [3:0] m_bank [4];
    logic [3:0] m_rd_a, m_rd_b;
    logic       m_last_b, m_port, m_we;
    logic [1:0] m_addr;
    logic [3:0] m_wd;
    int         t0, t_free;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int         ack_cnt;
        logic [11:0] ack_mask;
        logic        exp_gnt_b;

        // Single-transaction table from a cleared bank (entries 4/5 are ties; loser drops its request).
        tbl[0] = '{1'b1, 1'b0, 1'b1, 1'b0, 2'd2, 2'd0, 4'hD, 4'h0, 1'b0, 16'h0D00, 4'h0};
        tbl[1] = '{1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 2'd2, 4'h0, 4'h0, 1'b1, 16'h0D00, 4'hD};
        tbl[2] = '{1'b0, 1'b1, 1'b0, 1'b1, 2'd0, 2'd0, 4'h0, 4'h7, 1'b1, 16'h0D07, 4'h0};
        tbl[3] = '{1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 4'h0, 4'h0, 1'b0, 16'h0D07, 4'h7};
`ifdef BANCO_RR_EN
        tbl[4] = '{1'b1, 1'b1, 1'b1, 1'b1, 2'd3, 2'd3, 4'hA, 4'h5, 1'b1, 16'h5D07, 4'h0};
        tbl[5] = '{1'b1, 1'b1, 1'b1, 1'b0, 2'd1, 2'd3, 4'h3, 4'h0, 1'b0, 16'h5D37, 4'h0};
`else
        tbl[4] = '{1'b1, 1'b1, 1'b1, 1'b1, 2'd3, 2'd3, 4'hA, 4'h5, 1'b0, 16'hAD07, 4'h0};
        tbl[5] = '{1'b1, 1'b1, 1'b1, 1'b0, 2'd1, 2'd3, 4'h3, 4'h0, 1'b0, 16'hAD37, 4'h0};
`endif

        // Reset state.
        do_reset();
        tick(); tick();
        chk("reset_q_all", 32'(q_all), 32'h0);
        chk("reset_busy", 32'(busy), 32'h0);
        chk("reset_gnt_ack", 32'({gnt_a, gnt_b, ack_a, ack_b}), 32'h0);
        chk("reset_rdata", 32'({rdata_a, rdata_b}), 32'h0);

        // Table-driven single accesses.
        for (int i = 0; i < 6; i++) begin
            req_a = tbl[i].ra; req_b = tbl[i].rb; we_a = tbl[i].wa; we_b = tbl[i].wb;
            addr_a = tbl[i].aa; addr_b = tbl[i].ab; wdata_a = tbl[i].da; wdata_b = tbl[i].db;
            tick();
            req_a = 1'b0; req_b = 1'b0;
            chk($sformatf("v%0d_gnt", i), 32'({gnt_a, gnt_b, busy}), tbl[i].win_b ? 32'h3 : 32'h5);
            tick();
            chk($sformatf("v%0d_ack", i), 32'({ack_a, ack_b}), tbl[i].win_b ? 32'h1 : 32'h2);
            chk($sformatf("v%0d_q", i), 32'(q_all), 32'(tbl[i].q));
            if (tbl[i].win_b ? !tbl[i].wb : !tbl[i].wa) begin
                chk($sformatf("v%0d_rdata", i), 32'(tbl[i].win_b ? rdata_b : rdata_a), 32'(tbl[i].rd));
            end
            tick();
            chk($sformatf("v%0d_idle", i), 32'({gnt_a, gnt_b, ack_a, ack_b, busy}), 32'h0);
            tick();
        end

        // Tie with both holding requests: A first, B granted 3 cycles later, B's data lands last.
        do_reset();
        req_a = 1'b1; we_a = 1'b1; addr_a = 2'd0; wdata_a = 4'h2;
        req_b = 1'b1; we_b = 1'b1; addr_b = 2'd0; wdata_b = 4'h8;
        tick();
        chk("tie1_first", 32'({gnt_a, gnt_b}), 32'h2);
        tick();
        chk("tie1_ack_a", 32'(ack_a), 32'h1);
        chk("tie1_reg0_a", 32'(q_all[3:0]), 32'h2);
        req_a = 1'b0;
        tick();
        tick();
        chk("tie1_second", 32'({gnt_a, gnt_b}), 32'h1);
        req_b = 1'b0;
        tick();
        chk("tie1_ack_b", 32'(ack_b), 32'h1);
        chk("tie1_reg0_final", 32'(q_all[3:0]), 32'h8);
        tick(); tick();

        // A served alone, then a fresh tie: round-robin picks B, fixed priority still A.
        req_a = 1'b1; we_a = 1'b0; addr_a = 2'd0;
        tick();
        req_a = 1'b0;
        tick(); tick(); tick();
        req_a = 1'b1; we_a = 1'b0; req_b = 1'b1; we_b = 1'b0; addr_b = 2'd0;
        tick();
`ifdef BANCO_RR_EN
        exp_gnt_b = 1'b1;
`else
        exp_gnt_b = 1'b0;
`endif
        req_a = 1'b0; req_b = 1'b0;
        chk("tie2_winner", 32'({gnt_a, gnt_b}), exp_gnt_b ? 32'h1 : 32'h2);
        tick(); tick(); tick();

        // Command latch: inputs altered and request dropped during ACC.
        req_a = 1'b1; we_a = 1'b1; addr_a = 2'd1; wdata_a = 4'h5;
        tick();
        req_a = 1'b0; wdata_a = 4'hF; we_a = 1'b0; addr_a = 2'd3;
        ack_cnt = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (ack_a) ack_cnt++;
        end
        chk("latch_reg1", 32'(q_all[7:4]), 32'h5);
        chk("latch_ack_once", 32'(ack_cnt), 32'h1);

        // Reset while a write of 1111 to reg3 is in ACC.
        req_a = 1'b1; we_a = 1'b1; addr_a = 2'd3; wdata_a = 4'hF;
        tick();
        req_a = 1'b0;
        reset = 1'b1;
        tick();
        chk("rst_mid_ack", 32'({ack_a, gnt_a, busy}), 32'h0);
        chk("rst_mid_q", 32'(q_all), 32'h0);
        reset = 1'b0;
        ack_cnt = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (ack_a) ack_cnt++;
        end
        chk("rst_mid_no_ack", 32'(ack_cnt), 32'h0);
        chk("rst_mid_reg3", 32'(q_all[15:12]), 32'h0);

        // Held read for 9 cycles: acks at 3-cycle spacing, three in total.
        req_a = 1'b1; we_a = 1'b1; addr_a = 2'd0; wdata_a = 4'h9;
        tick();
        req_a = 1'b0;
        tick(); tick(); tick();
        req_a = 1'b1; we_a = 1'b0; addr_a = 2'd0;
        ack_mask = '0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (i == 8) req_a = 1'b0;
            ack_mask[i] = ack_a;
        end
        chk("hold_ack_pattern", 32'(ack_mask), 32'h092);
        chk("hold_rdata", 32'(rdata_a), 32'h9);

        // Random traffic against a transaction-level reference model.
        do_reset();
        for (int i = 0; i < 4; i++) m_bank[i] = 4'h0;
        m_rd_a = 4'h0; m_rd_b = 4'h0; m_last_b = 1'b1;
        m_port = 1'b0; m_we = 1'b0; m_addr = 2'd0; m_wd = 4'h0;
        t0 = -10; t_free = 0;
        for (int k = 0; k < 400; k++) begin
            logic act, ack;
            req_a = 1'($urandom_range(0, 1)); req_b = 1'($urandom_range(0, 1));
            we_a = 1'($urandom); we_b = 1'($urandom);
            addr_a = 2'($urandom); addr_b = 2'($urandom);
            wdata_a = 4'($urandom); wdata_b = 4'($urandom);
            tick();
            if (k >= t_free && (req_a || req_b)) begin
                if (req_a && req_b) begin
`ifdef BANCO_RR_EN
                    m_port = ~m_last_b;
`else
                    m_port = 1'b0;
`endif
                end else begin
                    m_port = req_b;
                end
                m_last_b = m_port;
                m_we   = m_port ? we_b : we_a;
                m_addr = m_port ? addr_b : addr_a;
                m_wd   = m_port ? wdata_b : wdata_a;
                t0 = k;
                t_free = k + 3;
            end
            act = (k == t0) || (k == t0 + 1);
            ack = (k == t0 + 1);
            if (ack) begin
                if (m_we) m_bank[m_addr] = m_wd;
                else if (m_port) m_rd_b = m_bank[m_addr];
                else m_rd_a = m_bank[m_addr];
            end
            chk($sformatf("rnd%0d_ctl", k), 32'({gnt_a, gnt_b, ack_a, ack_b, busy}),
                32'({act & ~m_port, act & m_port, ack & ~m_port, ack & m_port, act}));
            chk($sformatf("rnd%0d_rdata", k), 32'({rdata_a, rdata_b}), 32'({m_rd_a, m_rd_b}));
            chk($sformatf("rnd%0d_q", k), 32'(q_all),
                32'({m_bank[3], m_bank[2], m_bank[1], m_bank[0]}));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
